ascii_tile_stream: RTL
======================

# ascii_tile_stream

Streaming successor to the tile-based ASCII shader. It accepts RGB pixels one per cycle in raster order over a valid/ready handshake. It accumulates per-tile luminance for a full band of tiles in a per-column accumulator array, and emits one quantised ASCII level per tile, with tile coordinates and an end-of-frame marker, over a second valid/ready handshake. It sits between the pixel source (frame reader / scaler) and the glyph renderer, and replaces whole-tile parallel input with a narrow stream.

## Interface
- IMG_WIDTH, 640: active pixels per line; multiple of TILE_WIDTH.
- IMG_HEIGHT, 480: lines per frame; multiple of TILE_HEIGHT.
- TILE_WIDTH, 8: tile width in pixels; power of two.
- TILE_HEIGHT, 8: tile height in pixels; power of two.
- ASCII_LEVELS, 8: number of output levels; power of two, at most 2**COLOR_DEPTH.
- COLOR_DEPTH, 8: bits per colour channel.
- DATA_WIDTH, 3*COLOR_DEPTH: pixel width, packed R (MSBs), G, B (LSBs).
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- invert  in  1  when high, output level = ASCII_LEVELS-1-level; sampled on the cycle a tile completes.
- in_valid  in  1  pixel present.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- in_pixel  in  DATA_WIDTH  RGB pixel.
- out_valid  out  1  tile result present.
- out_ready  in  1  consumer takes result when out_valid && out_ready.
- out_level  out  $clog2(ASCII_LEVELS)  quantised level.
- out_tile_x  out  $clog2(IMG_WIDTH/TILE_WIDTH)  tile column.
- out_tile_y  out  $clog2(IMG_HEIGHT/TILE_HEIGHT)  tile row.
- out_last  out  1  last tile of frame (bottom-right).

## Operation
- Luminance per pixel: lum = (77*R + 150*G + 29*B) >> 8, width COLOR_DEPTH; 0xFFFFFF gives 255.
- Accumulators: NUM_COLS = IMG_WIDTH/TILE_WIDTH entries, each SUM_W = COLOR_DEPTH + $clog2(TILE_WIDTH*TILE_HEIGHT) bits. Overflow is impossible by construction.
- Counters: pixel x (0..IMG_WIDTH-1) and line y (0..IMG_HEIGHT-1) advance only on input accept. x wraps to 0 and increments y; y wraps to 0 after the last line.
- On accept, acc[x/TILE_WIDTH] += lum.
- A tile completes on the accept where y%TILE_HEIGHT == TILE_HEIGHT-1 and x%TILE_WIDTH == TILE_WIDTH-1. On completion:
  - avg = (acc+lum) >> $clog2(TILE_WIDTH*TILE_HEIGHT)
  - level = (avg*ASCII_LEVELS) >> COLOR_DEPTH, always at most ASCII_LEVELS-1, no clamp needed
  - apply invert
  - load the output register with level, tile_x, tile_y, and last = (x==IMG_WIDTH-1 && y==IMG_HEIGHT-1)
  - write that accumulator entry to 0 in the same cycle
- States:
  - IDLE (out_valid=0) goes to HOLD on completion.
  - HOLD (out_valid=1) goes to IDLE on out_ready with no new completion. It stays in HOLD, with new data loaded, on out_ready together with a simultaneous completion.
- in_ready = !out_valid || out_ready, registered-free combinational. Input stalls only while an unconsumed result is held. Non-completing pixels also stall in HOLD; this is the simple, decided rule.
- out_* fields stay stable while out_valid && !out_ready.
- Reset values:
  - in_ready=1 (combinational from out_valid=0)
  - out_valid=0, out_level=0, out_tile_x=0, out_tile_y=0, out_last=0
  - x=y=0, all accumulators 0
- Reset mid-frame discards all partial sums and any held result. The next accepted pixel is treated as frame pixel (0,0).

## Timing
- Result latency: out_valid is asserted on the cycle after the accept of the tile's final pixel.
- Throughput: one pixel per cycle while out_ready is held high. At most one result per TILE_WIDTH cycles.
- in_ready follows out_ready combinationally with no bubble. A consumer holding out_ready=1 never stalls the source.
- A simultaneous out_ready and completion replaces the result with no idle cycle.

## Structure
- Package ascii_pkg:
  - luminance function (shared with the existing shader)
  - luminance coefficients as constants
  - level quantisation function
  - tile_result_t struct {level, tile_x, tile_y, last}
- Sub-module ascii_tile_accum: accumulator array with read-add-write and clear-on-complete, NUM_COLS deep, single port.
- Top holds the counters, completion detect, quantiser and output register/handshake.

## Test plan
All cases use IMG 16x16, TILE 8x8, LEVELS 8, DEPTH 8, unless noted.
- All pixels 0xFFFFFF, out_ready=1 -> 4 results in order (0,0),(1,0),(0,1),(1,1); level 7; out_last only on (1,1).
- All 0x000000 with invert=1 -> all levels 7. The same frame with invert=0 -> levels 0.
- Tile (0,0) pure red 0xFF0000, other tiles black -> (0,0) level 2 (lum 76), others 0. Accumulators read 0 after each completion.
- out_ready=0 for 20 cycles after the first result -> out_* stable, in_ready=0, no pixel lost. The final sums match the unstalled run.
- Random in_valid/out_ready over 3 back-to-back frames -> levels match the reference model, and tile coordinates wrap correctly at each frame boundary.
- rst pulsed after 100 pixels -> out_valid=0 the next cycle. A fresh full white frame then yields exactly 4 results at level 7, with no stale partial sums.

Source files
------------

// File: rtl/ascii_pkg.sv
// Shared luminance / quantisation helpers and the tile result record used by
// the streaming ASCII shader.
package ascii_pkg;

    localparam int unsigned LUM_R       = 77;
    localparam int unsigned LUM_G       = 150;
    localparam int unsigned LUM_B       = 29;
    localparam int unsigned LUM_SHIFT   = 8;
    localparam int unsigned MAX_DEPTH   = 16;
    localparam int unsigned MAX_LEVEL_W = 8;
    localparam int unsigned MAX_COORD_W = 16;

    // Fields are sized for the largest supported geometry; users truncate.
    typedef struct packed {
        logic [MAX_LEVEL_W-1:0] level;
        logic [MAX_COORD_W-1:0] tile_x;
        logic [MAX_COORD_W-1:0] tile_y;
        logic                   last;
    } tile_result_t;

    function automatic logic [MAX_DEPTH-1:0] luminance(
        input logic [MAX_DEPTH-1:0] r,
        input logic [MAX_DEPTH-1:0] g,
        input logic [MAX_DEPTH-1:0] b
    );
        logic [31:0] acc;
        acc = LUM_R * 32'(r) + LUM_G * 32'(g) + LUM_B * 32'(b);
        return MAX_DEPTH'(acc >> LUM_SHIFT);
    endfunction

    function automatic logic [MAX_LEVEL_W-1:0] quantise(
        input logic [MAX_DEPTH-1:0] avg,
        input int unsigned          level_bits,
        input int unsigned          depth
    );
        logic [31:0] t;
        t = (32'(avg) << level_bits) >> depth;
        return MAX_LEVEL_W'(t);
    endfunction

endpackage

// File: rtl/ascii_tile_stream_if.sv
// Pixel-in / tile-result-out handshake bundle for ascii_tile_stream.
interface ascii_tile_stream_if #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned LEVEL_W    = 3,
    parameter int unsigned TX_W       = 7,
    parameter int unsigned TY_W       = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_pixel;
    logic                  out_valid;
    logic                  out_ready;
    logic [LEVEL_W-1:0]    out_level;
    logic [TX_W-1:0]       out_tile_x;
    logic [TY_W-1:0]       out_tile_y;
    logic                  out_last;

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_level, out_tile_x, out_tile_y, out_last
    );

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_level, out_tile_x, out_tile_y, out_last
    );
endinterface

// File: rtl/ascii_tile_accum.sv
// Per-column luminance accumulators: single-port read-add-write, with the
// addressed entry cleared instead of written when its tile completes.
module ascii_tile_accum #(
    parameter int unsigned NUM_COLS    = 80,
    parameter int unsigned COL_W       = 7,
    parameter int unsigned SUM_W       = 14,
    parameter int unsigned COLOR_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clear,
    input  logic [COL_W-1:0]       col,
    input  logic [COLOR_DEPTH-1:0] lum,
    output logic [SUM_W-1:0]       sum
);
    logic [SUM_W-1:0] acc_q [NUM_COLS];
    logic [SUM_W-1:0] acc_d [NUM_COLS];

    assign sum = acc_q[col] + SUM_W'(lum);

    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d[col] = clear ? '0 : sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '{default: '0};
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/ascii_tile_stream.sv
// Streaming tile shader: raster pixels in, one quantised ASCII level per tile
// out, with tile coordinates and an end-of-frame flag.
module ascii_tile_stream import ascii_pkg::*; #(
    parameter int unsigned IMG_WIDTH    = 640,
    parameter int unsigned IMG_HEIGHT   = 480,
    parameter int unsigned TILE_WIDTH   = 8,
    parameter int unsigned TILE_HEIGHT  = 8,
    parameter int unsigned ASCII_LEVELS = 8,
    parameter int unsigned COLOR_DEPTH  = 8,
    parameter int unsigned DATA_WIDTH   = 3 * COLOR_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic invert,
    ascii_tile_stream_if.slave bus
);
    localparam int unsigned NUM_COLS  = IMG_WIDTH / TILE_WIDTH;
    localparam int unsigned TILE_LOG2 = $clog2(TILE_WIDTH * TILE_HEIGHT);
    localparam int unsigned SUM_W     = COLOR_DEPTH + TILE_LOG2;
    localparam int unsigned X_W       = $clog2(IMG_WIDTH);
    localparam int unsigned Y_W       = $clog2(IMG_HEIGHT);
    localparam int unsigned TXB       = $clog2(TILE_WIDTH);
    localparam int unsigned TYB       = $clog2(TILE_HEIGHT);
    localparam int unsigned TX_W      = $clog2(NUM_COLS);
    localparam int unsigned TY_W      = $clog2(IMG_HEIGHT / TILE_HEIGHT);
    localparam int unsigned LEVEL_W   = $clog2(ASCII_LEVELS);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t                 state_q, state_d;
    tile_result_t           res_q, res_d;
    logic [X_W-1:0]         x_q, x_d;
    logic [Y_W-1:0]         y_q, y_d;
    logic                   accept, complete, x_end, y_end;
    logic [COLOR_DEPTH-1:0] lum, avg;
    logic [SUM_W-1:0]       sum;
    logic [LEVEL_W-1:0]     level_raw, level;

    assign bus.in_ready = (state_q == S_IDLE) || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign x_end        = (x_q == X_W'(IMG_WIDTH - 1));
    assign y_end        = (y_q == Y_W'(IMG_HEIGHT - 1));
    assign complete     = accept
                       && (x_q[TXB-1:0] == TXB'(TILE_WIDTH - 1))
                       && (y_q[TYB-1:0] == TYB'(TILE_HEIGHT - 1));

    assign lum = COLOR_DEPTH'(luminance(
        MAX_DEPTH'(bus.in_pixel[DATA_WIDTH-1 -: COLOR_DEPTH]),
        MAX_DEPTH'(bus.in_pixel[2*COLOR_DEPTH-1 -: COLOR_DEPTH]),
        MAX_DEPTH'(bus.in_pixel[COLOR_DEPTH-1:0])));

    ascii_tile_accum #(
        .NUM_COLS    (NUM_COLS),
        .COL_W       (TX_W),
        .SUM_W       (SUM_W),
        .COLOR_DEPTH (COLOR_DEPTH)
    ) u_accum (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .clear (complete),
        .col   (x_q[X_W-1:TXB]),
        .lum   (lum),
        .sum   (sum)
    );

    // sum already includes the completing pixel's luminance.
    assign avg       = COLOR_DEPTH'(sum >> TILE_LOG2);
    assign level_raw = LEVEL_W'(quantise(MAX_DEPTH'(avg), LEVEL_W, COLOR_DEPTH));
    assign level     = invert ? LEVEL_W'(ASCII_LEVELS - 1) - level_raw : level_raw;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (accept) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // A completion can only be accepted in HOLD when out_ready is high, so
    // loading on completion covers both IDLE->HOLD and HOLD-replace.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        if (complete) begin
            state_d      = S_HOLD;
            res_d.level  = MAX_LEVEL_W'(level);
            res_d.tile_x = MAX_COORD_W'(x_q[X_W-1:TXB]);
            res_d.tile_y = MAX_COORD_W'(y_q[Y_W-1:TYB]);
            res_d.last   = x_end && y_end;
        end else if (state_q == S_HOLD && bus.out_ready) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign bus.out_valid  = (state_q == S_HOLD);
    assign bus.out_level  = LEVEL_W'(res_q.level);
    assign bus.out_tile_x = TX_W'(res_q.tile_x);
    assign bus.out_tile_y = TY_W'(res_q.tile_y);
    assign bus.out_last   = res_q.last;
endmodule
